// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter/sequencer.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW     = 2'd2
  } state_t;

  localparam int        RAM_AW_DEF  = 14;
  localparam int        DATA_W_DEF  = 32;
  localparam logic [3:0] BE_FULL    = 4'hF;
  localparam int        NUM_M       = 2;
  localparam logic      M0          = 1'b0;
  localparam logic      M1          = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master's request/response channel into the data-RAM arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_be_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes take new data, others keep old.
module be_merge #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
) (
  input  logic [NUM_LANES-1:0]             be,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] newData,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] oldData,
  output logic [NUM_LANES-1:0][LANE_W-1:0] merged
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    assign merged[i] = be[i] ? newData[i] : oldData[i];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data RAM; partial stores become
// a read cycle followed by a merged write.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  dmem_arbiter_if.slave      m0,
  dmem_arbiter_if.slave      m1,
  output logic               ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [NUM_M-1:0]                  reqV, weV;
  logic [NUM_M-1:0][RAM_AW-1:0]      wordV;
  logic [NUM_M-1:0][DATA_W-1:0]      wdataV;
  logic [NUM_M-1:0][BE_W-1:0]        beV;

  assign reqV   = {m1.req, m0.req};
  assign weV    = {m1.we, m0.we};
  assign wordV  = {m1.addr[RAM_AW+1:2], m0.addr[RAM_AW+1:2]};
  assign wdataV = {m1.wdata, m0.wdata};
  assign beV    = {m1.be, m0.be};

  // Byte offset and bits above the RAM window alias onto the same word.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{m0.addr[1:0], m0.addr[31:RAM_AW+2],
                            m1.addr[1:0], m1.addr[31:RAM_AW+2]};

  state_t                       state;
  logic                         prio;
  logic                         win;
  logic [NUM_M-1:0]             gntV;
  logic [RAM_AW-1:0]            latAddr;
  logic [DATA_W-1:0]            latWdata;
  logic [BE_W-1:0]              latBe;
  logic [NUM_M-1:0]             rvalidQ;
  logic [NUM_M-1:0][DATA_W-1:0] rdataQ;
  logic [DATA_W-1:0]            mergedData;

  logic              selWe, isFull, isPartial;
  logic [RAM_AW-1:0] selWord;
  logic [DATA_W-1:0] selWdata;
  logic [BE_W-1:0]   selBe;

  // Grant is combinational so the RAM sees the winner's command in the same cycle.
  always_comb begin
    gntV = '0;
    win  = prio;
    if (state == IDLE && !reset) begin
      if (reqV[M0] && reqV[M1]) win = prio;
      else if (reqV[M1])        win = M1;
      else                      win = M0;
      if (|reqV) gntV[win] = 1'b1;
    end
  end

  assign selWe     = weV[win];
  assign selWord   = wordV[win];
  assign selWdata  = wdataV[win];
  assign selBe     = beV[win];
  assign isFull    = &selBe;
  assign isPartial = (|selBe) && !isFull;

  be_merge #(.NUM_LANES(BE_W), .LANE_W(8)) uMerge (
    .be      (latBe),
    .newData (latWdata),
    .oldData (ram_rdata),
    .merged  (mergedData)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (|gntV) begin
          ram_addr = selWord;
          if (selWe && isFull) begin
            ram_we    = 1'b1;
            ram_wdata = selWdata;
          end
        end
      end
      RD_WAIT: ram_addr = latAddr;
      RMW: begin
        ram_we    = 1'b1;
        ram_addr  = latAddr;
        ram_wdata = mergedData;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= M0;
      latAddr  <= '0;
      latWdata <= '0;
      latBe    <= '0;
      rvalidQ  <= '0;
      rdataQ   <= '0;
    end else begin
      rvalidQ <= '0;
      for (int m = 0; m < NUM_M; m++)
        if (rvalidQ[m]) rdataQ[m] <= ram_rdata;
      case (state)
        IDLE: begin
          if (|gntV) begin
            prio     <= ~win;
            latAddr  <= selWord;
            latWdata <= selWdata;
            latBe    <= selBe;
            if (!selWe) begin
              // rvalid lines up with the cycle the RAM returns data.
              rvalidQ[win] <= 1'b1;
              state        <= RD_WAIT;
            end else if (isPartial) begin
              state <= RMW;
            end
          end
        end
        RD_WAIT: state <= IDLE;
        RMW:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m0.gnt    = gntV[M0];
  assign m1.gnt    = gntV[M1];
  assign m0.rvalid = rvalidQ[M0];
  assign m1.rvalid = rvalidQ[M1];
  assign m0.rdata  = rvalidQ[M0] ? ram_rdata : rdataQ[M0];
  assign m1.rdata  = rvalidQ[M1] ? ram_rdata : rdataQ[M1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized checks of dmem_arbiter against a word-array memory model.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.DATA_W(32)) m0if();
  dmem_arbiter_if #(.DATA_W(32)) m1if();

  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  dmem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .m0        (m0if),
    .m1        (m1if),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [31:0] mem    [16384];
  logic [31:0] refMem [16384];

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int   total = 0;
  int   bad   = 0;
  int   expPrio = 0;

  wire [1:0]  gntV = {m1if.gnt, m0if.gnt};
  wire [1:0]  rvV  = {m1if.rvalid, m0if.rvalid};
  wire [31:0] rd0  = m0if.rdata;
  wire [31:0] rd1  = m1if.rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wordOf(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FFF);
  endfunction

  function automatic logic [31:0] mergeModel(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      m0if.req = req; m0if.we = we; m0if.addr = addr; m0if.wdata = wdata; m0if.be = be;
    end else begin
      m1if.req = req; m1if.we = we; m1if.addr = addr; m1if.wdata = wdata; m1if.be = be;
    end
  endtask

  // One transaction from a single requester; called just after a rising edge.
  task automatic doTxn(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int   w;
    bit   got;
    logic full;
    logic [31:0] merged;
    w   = wordOf(addr);
    got = 0;
    drive(m, 1'b1, we, addr, wdata, be);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (gntV != 2'b00) begin got = 1; break; end
      @(posedge clock); #1;
    end
    if (!got) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      return;
    end
    full = we && (be == 4'hF);
    chk("gnt_onehot", 32'(gntV), 32'(2'b01 << m));
    chk("ram_addr_T", 32'(ram_addr), 32'(w));
    chk("ram_we_T", 32'(ram_we), 32'(full));
    if (full) chk("ram_wdata_T", ram_wdata, wdata);
    expPrio = 1 - m;
    @(posedge clock); #1;
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    if (full) refMem[w] = wdata;
    if (!we) begin
      @(negedge clock);
      chk("rvalid", 32'(rvV), 32'(2'b01 << m));
      chk("rdata", (m == 0) ? rd0 : rd1, refMem[w]);
      chk("ram_we_rd", 32'(ram_we), 32'd0);
      @(posedge clock); #1;
    end else if (be != 4'h0 && be != 4'hF) begin
      @(negedge clock);
      merged = mergeModel(refMem[w], wdata, be);
      chk("rmw_we", 32'(ram_we), 32'd1);
      chk("rmw_addr", 32'(ram_addr), 32'(w));
      chk("rmw_wdata", ram_wdata, merged);
      chk("rmw_no_rvalid", 32'(rvV), 32'd0);
      refMem[w] = merged;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int winner;
    int rm, ridx;
    logic [31:0] ra, rdv;
    logic [3:0]  rbe;
    logic        rwe;
    logic [31:0] d4 [4];

    for (int i = 0; i < 16384; i++) begin mem[i] = 32'd0; refMem[i] = 32'd0; end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    // Reset state
    @(posedge clock); @(negedge clock);
    chk("rst_gnt", 32'(gntV), 32'd0);
    chk("rst_rvalid", 32'(rvV), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    expPrio = 0;

    // 1: full store then load
    doTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    doTxn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clock);
    chk("rdata_hold", rd0, 32'hDEADBEEF);
    chk("rvalid_pulse", 32'(rvV), 32'd0);
    @(posedge clock); #1;

    // 2: partial store RMW
    doTxn(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    doTxn(1, 1'b1, 32'h20, 32'h0000AA00, 4'b0010);
    chk("rmw_result", refMem[8], 32'h1122AA44);
    doTxn(1, 1'b0, 32'h20, 32'h0, 4'h0);

    // 3: contention, both loading continuously
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      winner = expPrio;
      chk("arb_gnt", 32'(gntV), 32'(2'b01 << winner));
      expPrio = 1 - winner;
      @(posedge clock); #1;
      @(negedge clock);
      chk("arb_wait_gnt", 32'(gntV), 32'd0);
      chk("arb_rvalid", 32'(rvV), 32'(2'b01 << winner));
      chk("arb_rdata", (winner == 0) ? rd0 : rd1, refMem[(winner == 0) ? 4 : 8]);
      @(posedge clock); #1;
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    // 4: back-to-back full stores from m0
    for (int i = 0; i < 4; i++) d4[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, 32'h100 + 32'(4*i), d4[i], 4'hF);
      @(negedge clock);
      chk("b2b_gnt", 32'(gntV), 32'd1);
      chk("b2b_we", 32'(ram_we), 32'd1);
      chk("b2b_addr", 32'(ram_addr), 32'(64 + i));
      chk("b2b_wdata", ram_wdata, d4[i]);
      @(posedge clock); #1;
      refMem[64 + i] = d4[i];
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    expPrio = 1;
    doTxn(1, 1'b0, 32'h108, 32'h0, 4'h0);

    // 5: reset during RMW write cycle
    doTxn(0, 1'b1, 32'h40, 32'h55667788, 4'hF);
    drive(0, 1'b1, 1'b1, 32'h40, 32'h000000FF, 4'b0001);
    @(negedge clock);
    chk("r5_gnt", 32'(gntV), 32'd1);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("r5_ram_we", 32'(ram_we), 32'd0);
    chk("r5_ram_addr", 32'(ram_addr), 32'd0);
    chk("r5_gnt_off", 32'(gntV), 32'd0);
    chk("r5_rvalid", 32'(rvV), 32'd0);
    chk("r5_rd0", rd0, 32'd0);
    chk("r5_rd1", rd1, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    expPrio = 0;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clock);
    chk("r5_prio_m0", 32'(gntV), 32'd1);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    expPrio = 1;
    @(negedge clock);
    chk("r5_rvalid0", 32'(rvV), 32'd1);
    chk("r5_word_kept", rd0, 32'h55667788);
    @(posedge clock); #1;

    // 6: be=0 store and address aliasing
    doTxn(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    doTxn(1, 1'b1, 32'h30, 32'h12345678, 4'h0);
    doTxn(0, 1'b0, 32'h30, 32'h0, 4'h0);
    doTxn(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
    doTxn(0, 1'b0, 32'h00030003, 32'h0, 4'h0);

    // Randomized single-requester traffic over a small word window
    for (int n = 0; n < 60; n++) begin
      rm   = int'($urandom_range(0, 1));
      ridx = int'($urandom_range(0, 15));
      ra   = ($urandom & 32'hFFFF_0003) | (32'(ridx) << 2);
      rdv  = $urandom;
      rwe  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rbe = 4'hF;
        1:       rbe = 4'h0;
        default: rbe = 4'($urandom_range(1, 14));
      endcase
      doTxn(rm, rwe, ra, rdv, rbe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
